// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate engine: moves the operand up to STEP bits per clock
// under a start/done handshake. The result is held until the next completion.
module shift_rotate_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_operand,
  input  logic [WIDTH-1:0] i_amount,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  // LW indexes a bit position; RW holds a count from 0 to WIDTH inclusive.
  localparam int unsigned LW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [RW-1:0]    r_rem;
  logic [2:0]       r_op;
  logic             r_sign;
  logic [WIDTH-1:0] r_result;

  logic [RW-1:0]      w_amt_sat;
  logic [RW-1:0]      w_amt_mod;
  logic [RW-1:0]      w_count;
  logic [RW-1:0]      w_step;
  logic [RW-1:0]      w_rem_next;
  logic [2*WIDTH-1:0] w_wide;
  logic [WIDTH-1:0]   w_shifted;

  // Effective count from the raw amount: saturating for shifts, modulo for rotates.
  always_comb begin
    w_amt_sat = (i_amount >= WIDTH'(WIDTH)) ? RW'(WIDTH) : RW'(i_amount);
    w_amt_mod = RW'(i_amount[LW-1:0]);
    w_count   = '0;
    case (i_op)
      OP_SHR, OP_SHRA, OP_SHL: w_count = w_amt_sat;
      OP_ROR, OP_ROL:          w_count = w_amt_mod;
      default:                 w_count = '0;
    endcase
  end

  // Bits moved this cycle, and the count left over afterwards.
  always_comb begin
    w_step     = (r_rem > RW'(STEP)) ? RW'(STEP) : r_rem;
    w_rem_next = r_rem - w_step;
  end

  // One partial shift of the work register; the doubled vector supplies
  // sign fill for SHRA and the wrap-around bits for the rotates.
  always_comb begin
    w_wide    = '0;
    w_shifted = r_work;
    case (r_op)
      OP_SHR: w_shifted = r_work >> w_step;
      OP_SHRA: begin
        w_wide    = {{WIDTH{r_sign}}, r_work} >> w_step;
        w_shifted = w_wide[WIDTH-1:0];
      end
      OP_SHL: w_shifted = r_work << w_step;
      OP_ROR: begin
        w_wide    = {r_work, r_work} >> w_step;
        w_shifted = w_wide[WIDTH-1:0];
      end
      OP_ROL: begin
        w_wide    = {r_work, r_work} << w_step;
        w_shifted = w_wide[2*WIDTH-1:WIDTH];
      end
      default: w_shifted = r_work;
    endcase
  end

  // Control FSM with datapath registers; clear discards any in-flight operation.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_rem    <= '0;
      r_op     <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_work <= i_operand;
            r_rem  <= w_count;
            r_op   <= i_op;
            r_sign <= i_operand[WIDTH-1];
            if (w_count != '0) begin
              r_state <= S_RUN;
            end else begin
              r_state  <= S_DONE;
              r_result <= i_operand;
            end
          end
        end
        S_RUN: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state  <= S_DONE;
            r_result <= w_shifted;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status decodes straight from the state and result registers.
  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_zero   = (r_result == '0);

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Randomised and directed checks of shift_rotate_unit against a one-shot arithmetic model.
`timescale 1ns/1ps
module tb_shift_rotate_unit;

  logic        clk;
  logic        i_clear;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_operand;
  logic [31:0] i_amount;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;
  logic        o_zero;

  int total = 0;
  int bad   = 0;

  shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut (
    .i_clock   (clk),
    .i_clear   (i_clear),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_operand (i_operand),
    .i_amount  (i_amount),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_result  (o_result),
    .o_zero    (o_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole shift in one step with plain operators.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] amt);
    int n;
    n = int'(amt % 32);
    case (op)
      3'd0: return (amt >= 32) ? 32'd0 : (a >> amt);
      3'd1: return (amt >= 32) ? {32{a[31]}} : 32'($signed(a) >>> amt);
      3'd2: return (amt >= 32) ? 32'd0 : (a << amt);
      3'd3: return (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      3'd4: return (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      default: return a;
    endcase
  endfunction

  // Reference latency in cycles from the start edge to the done cycle.
  function automatic int model_lat(input logic [2:0] op, input logic [31:0] amt);
    int c;
    case (op)
      3'd0, 3'd1, 3'd2: c = (amt >= 32) ? 32 : int'(amt);
      3'd3, 3'd4:       c = int'(amt % 32);
      default:          c = 0;
    endcase
    return (c + 3) / 4 + 1;
  endfunction

  // Present a request for exactly one edge; returns in the cycle after that edge.
  task automatic do_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] amt);
    @(negedge clk);
    i_op      = op;
    i_operand = a;
    i_amount  = amt;
    i_start   = 1'b1;
    @(posedge clk);
    #1;
    i_start   = 1'b0;
  endtask

  // Wait (bounded) for done; lat = -1 on timeout. Returns in the cycle after done.
  task automatic wait_done(output int lat, output logic [31:0] res, output logic zr,
                           output int busy_cnt);
    lat = -1;
    res = 'x;
    zr = 1'bx;
    busy_cnt = 0;
    for (int n = 1; n <= 100; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (o_busy) busy_cnt++;
      if (o_done) begin
        lat = n;
        res = o_result;
        zr  = o_zero;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    i_clear = 1'b1;
    i_start = 1'b0;
    i_op = '0;
    i_operand = '0;
    i_amount = '0;
    repeat (3) @(posedge clk);
    #1;
    i_clear = 1'b0;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    total++; if (o_result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", o_result); end
    total++; if (o_zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", o_zero); end
  endtask

  task automatic test_directed;
    int lat, bc;
    logic [31:0] res;
    logic zr;
    do_start(3'd0, 32'h34, 32'd2);
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'h0000000D) begin bad++; $display("FAIL shr_result: got %h want 0000000d", res); end
    total++; if (lat !== 2) begin bad++; $display("FAIL shr_latency: got %0d want 2", lat); end
    total++; if (zr !== 1'b0) begin bad++; $display("FAIL shr_zero: got %b want 0", zr); end

    do_start(3'd1, 32'h80000000, 32'd35);
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'hFFFFFFFF) begin bad++; $display("FAIL shra_neg_result: got %h want ffffffff", res); end
    total++; if (bc !== 9) begin bad++; $display("FAIL shra_busy_cycles: got %0d want 9", bc); end
    total++; if (lat !== 9) begin bad++; $display("FAIL shra_latency: got %0d want 9", lat); end

    do_start(3'd1, 32'h40000000, 32'd35);
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'h0) begin bad++; $display("FAIL shra_pos_result: got %h want 00000000", res); end
    total++; if (zr !== 1'b1) begin bad++; $display("FAIL shra_pos_zero: got %b want 1", zr); end

    do_start(3'd4, 32'h80000001, 32'd36);
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'h00000018) begin bad++; $display("FAIL rol_result: got %h want 00000018", res); end
    total++; if (lat !== 2) begin bad++; $display("FAIL rol_latency: got %0d want 2", lat); end

    do_start(3'd3, 32'hF1, 32'd8);
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'hF1000000) begin bad++; $display("FAIL ror_result: got %h want f1000000", res); end
    total++; if (lat !== 3) begin bad++; $display("FAIL ror_latency: got %0d want 3", lat); end
    total++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL done_one_cycle: got done=%b busy=%b want 0 0", o_done, o_busy);
    end

    do_start(3'd2, 32'h12345678, 32'd0);
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'h12345678) begin bad++; $display("FAIL shl0_result: got %h want 12345678", res); end
    total++; if (lat !== 1) begin bad++; $display("FAIL shl0_latency: got %0d want 1", lat); end

    do_start(3'd6, 32'h12345678, $urandom);
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'h12345678) begin bad++; $display("FAIL pass_result: got %h want 12345678", res); end
    total++; if (lat !== 1) begin bad++; $display("FAIL pass_latency: got %0d want 1", lat); end
  endtask

  task automatic test_ignore_and_clear;
    int lat, bc, dcnt;
    logic [31:0] res;
    logic zr;
    do_start(3'd2, 32'h1, 32'd20);
    @(negedge clk);
    i_op = 3'd0; i_operand = 32'hFFFFFFFF; i_amount = 32'd3; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'h00100000) begin bad++; $display("FAIL ignore_result: got %h want 00100000", res); end
    total++; if (lat !== 5) begin bad++; $display("FAIL ignore_latency: got %0d want 5", lat); end

    do_start(3'd2, 32'h1, 32'd20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL clear_busy: got %b want 0", o_busy); end
    total++; if (o_result !== 32'h0) begin bad++; $display("FAIL clear_result: got %h want 0", o_result); end
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_done) dcnt++;
      @(posedge clk); #1;
    end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL clear_no_done: got %0d pulses want 0", dcnt); end

    do_start(3'd2, 32'h1, 32'd20);
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'h00100000) begin bad++; $display("FAIL fresh_result: got %h want 00100000", res); end
    total++; if (lat !== 6) begin bad++; $display("FAIL fresh_latency: got %0d want 6", lat); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [31:0] res;
    logic zr;
    do_start(3'd0, 32'h34, 32'd2);
    wait_done(lat, res, zr, bc);
    do_start(3'd3, 32'hF1, 32'd8);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", o_busy); end
    total++; if (o_result !== 32'h0000000D) begin bad++; $display("FAIL b2b_hold: got %h want 0000000d", o_result); end
    wait_done(lat, res, zr, bc);
    total++; if (res !== 32'hF1000000) begin bad++; $display("FAIL b2b_result: got %h want f1000000", res); end
    total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency: got %0d want 3", lat); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [31:0] res, a, amt, exp_res;
    logic [2:0] op;
    logic zr;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      amt = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 70));
      exp_res = model_result(op, a, amt);
      do_start(op, a, amt);
      wait_done(lat, res, zr, bc);
      total++; if (res !== exp_res) begin
        bad++; $display("FAIL rand_result op=%0d a=%h amt=%0d: got %h want %h", op, a, amt, res, exp_res);
      end
      total++; if (lat !== model_lat(op, amt)) begin
        bad++; $display("FAIL rand_latency op=%0d amt=%0d: got %0d want %0d", op, amt, lat, model_lat(op, amt));
      end
      total++; if (zr !== (exp_res == 32'd0)) begin
        bad++; $display("FAIL rand_zero: got %b want %b", zr, (exp_res == 32'd0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_and_clear();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
